ttl161_timer_ctrl: RTL and testbench

Sequencer for a cascade of STAGES 4-bit 74ALS161-style synchronous counters (ripple-carry chained) on the test board, used as a programmable interval timer. On start it computes and loads the preset, gates count-enable from a tick strobe, detects terminal count through the chain's carry-out, and either stops (one-shot) or reloads (periodic). A shadow down-counter cross-checks the external chain and flags a sticky fault on any carry mismatch.

---
 rtl/ttl161_timer_ctrl.sv | 116 +++++++++++
 tb/tb_ttl161_timer_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ttl161_timer_ctrl.sv
// Interval-timer sequencer driving a cascade of 74ALS161-style 4-bit counters.
// Loads the preset, gates count-enable from the tick strobe, and cross-checks the chain's carry against a shadow counter.
module ttl161_timer_ctrl #(
    parameter int unsigned STAGES      = 2,
    parameter bit          FAULT_CHECK = 1'b1,
    localparam int unsigned W          = 4 * STAGES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         periodic,
    input  logic [W-1:0] period,
    input  logic         tick_en,
    input  logic         fault_clr,
    output logic         ctr_clr_n,
    output logic         ctr_load,
    output logic         ctr_count,
    output logic [W-1:0] ctr_d,
    input  logic         ctr_tc,
    output logic         busy,
    output logic         expire,
    output logic         fault,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t       state_q;
    logic [W-1:0] preset_q;
    logic [W-1:0] n_q;
    logic [W-1:0] rem_q;
    logic         periodic_q;
    logic         expire_q;
    logic         clr_n_q;

    logic tick;
    logic rem_zero;
    logic busy_w;
    logic fault_det;
    logic terminal;

    // Count-enable never depends on ctr_tc, so the chip's carry gating cannot close a loop.
    assign busy_w   = (state_q == S_LOAD) || (state_q == S_COUNT);
    assign tick     = (state_q == S_COUNT) && tick_en && !abort;
    assign rem_zero = (rem_q == '0);

    assign fault_det = FAULT_CHECK && busy_w && !abort &&
                       ((tick && rem_zero && !ctr_tc) ||
                        (tick && !rem_zero && ctr_tc) ||
                        (ctr_tc && !tick));
    assign terminal  = tick && ctr_tc && !fault_det;

    assign ctr_count = tick;
    // Load wins over count inside the chip, so a periodic reload goes straight back to the preset.
    assign ctr_load  = (state_q == S_LOAD) || (terminal && periodic_q);
    assign ctr_d     = preset_q;
    assign ctr_clr_n = clr_n_q;
    assign busy      = busy_w;
    assign expire    = expire_q;
    assign fault     = (state_q == S_FAULT);
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            preset_q   <= '0;
            n_q        <= '0;
            rem_q      <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            clr_n_q    <= 1'b0;
        end else begin
            clr_n_q  <= 1'b1;
            expire_q <= terminal;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        n_q        <= period;
                        preset_q   <= '0 - period;
                        periodic_q <= periodic;
                        state_q    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    rem_q <= n_q - 1'b1;
                    if (abort)          state_q <= S_IDLE;
                    else if (fault_det) state_q <= S_FAULT;
                    else                state_q <= S_COUNT;
                end
                S_COUNT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else if (fault_det) begin
                        state_q <= S_FAULT;
                    end else if (terminal) begin
                        rem_q <= n_q - 1'b1;
                        if (!periodic_q) state_q <= S_IDLE;
                    end else if (tick) begin
                        rem_q <= rem_q - 1'b1;
                    end
                end
                S_FAULT: begin
                    if (fault_clr) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttl161_timer_ctrl.sv
// Directed bench for ttl161_timer_ctrl with a behavioural model of the 8-bit counter chain.
module tb_ttl161_timer_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, abort, periodic, tick_en, fault_clr;
  logic [W-1:0] period;
  logic         ctr_clr_n, ctr_load, ctr_count, ctr_tc;
  logic [W-1:0] ctr_d;
  logic         busy, expire, fault;
  logic [1:0]   state_dbg;

  logic [W-1:0] chip_q;
  logic         force_tc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ttl161_timer_ctrl #(.STAGES(2), .FAULT_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .periodic(periodic),
    .period(period), .tick_en(tick_en), .fault_clr(fault_clr),
    .ctr_clr_n(ctr_clr_n), .ctr_load(ctr_load), .ctr_count(ctr_count),
    .ctr_d(ctr_d), .ctr_tc(ctr_tc), .busy(busy), .expire(expire),
    .fault(fault), .state_dbg(state_dbg)
  );

  // Cascaded '161 chain: clear, then load, then count; carry gated by count-enable.
  always @(posedge clk) begin
    if (!ctr_clr_n)    chip_q <= '0;
    else if (ctr_load) chip_q <= ctr_d;
    else if (ctr_count) chip_q <= chip_q + 1'b1;
  end
  assign ctr_tc = force_tc | (ctr_count & (chip_q == 8'hFF));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int highs;
    bit done;
    rst = 1'b1; start = 0; abort = 0; periodic = 0; tick_en = 0;
    fault_clr = 0; period = '0; force_tc = 0;

    // reset
    cyc(); cyc();
    check("rst_clr_n", ctr_clr_n, 0);
    check("rst_busy", busy, 0);
    check("rst_load", ctr_load, 0);
    check("rst_count", ctr_count, 0);
    check("rst_d", ctr_d, 0);
    check("rst_expire", expire, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    cyc();
    check("rst_clr_n_rel", ctr_clr_n, 1);
    check("rst_chip", chip_q, 0);

    // one-shot, period 5
    period = 8'd5; periodic = 0; tick_en = 1; start = 1;
    cyc();
    start = 0; #1;
    check("os_load", ctr_load, 1);
    check("os_d", ctr_d, 8'hFB);
    check("os_busy_load", busy, 1);
    check("os_count_in_load", ctr_count, 0);
    for (int i = 2; i <= 6; i++) begin
      cyc();
      check("os_count", ctr_count, 1);
      check("os_tc", ctr_tc, (i == 6));
      check("os_no_expire", expire, 0);
    end
    cyc();
    check("os_expire", expire, 1);
    check("os_busy_end", busy, 0);
    check("os_chip_end", chip_q, 8'h00);
    cyc();
    check("os_expire_pulse", expire, 0);

    // periodic, period 3; period change while busy must be ignored
    period = 8'd3; periodic = 1; start = 1;
    cyc();
    start = 0; period = 8'd7; periodic = 0;
    cyc();
    for (int k = 0; k < 9; k++) begin
      check("per_chip", chip_q, 8'hFD + (k % 3));
      check("per_load", ctr_load, (k % 3 == 2));
      check("per_expire", expire, (k > 0 && k % 3 == 0));
      cyc();
    end
    check("per_wrap", chip_q, 8'hFD);
    check("per_expire_last", expire, 1);
    abort = 1; #1;
    check("abort_count", ctr_count, 0);
    check("abort_load", ctr_load, 0);
    cyc();
    abort = 0;
    check("abort_busy", busy, 0);
    check("abort_expire", expire, 0);
    cyc(); cyc();
    check("abort_no_expire", expire, 0);
    check("abort_chip_hold", chip_q, 8'hFD);

    // period 0 = 256 ticks, steady then toggling tick_en
    for (int mode = 0; mode < 2; mode++) begin
      period = 8'd0; periodic = 0; tick_en = 1; start = 1;
      cyc();
      start = 0; #1;
      check("p0_d", ctr_d, 8'h00);
      cyc();
      highs = 0; done = 0;
      for (int n = 0; n < 1000 && !done; n++) begin
        tick_en = (mode == 0) ? 1'b1 : (n % 2 == 0);
        #1;
        if (ctr_count) highs++;
        cyc();
        if (expire) done = 1;
      end
      check("p0_expired", done, 1);
      check("p0_ticks", highs, 256);
      check("p0_busy", busy, 0);
      check("p0_chip", chip_q, 8'h00);
    end

    // injected carry on 2nd tick of period 5
    period = 8'd5; periodic = 0; tick_en = 1; start = 1;
    cyc();
    start = 0;
    cyc();
    cyc();
    force_tc = 1; #1;
    check("flt_count_pre", ctr_count, 1);
    cyc();
    force_tc = 0; #1;
    check("flt_fault", fault, 1);
    check("flt_busy", busy, 0);
    check("flt_count", ctr_count, 0);
    check("flt_load", ctr_load, 0);
    check("flt_expire", expire, 0);
    start = 1;
    cyc();
    start = 0;
    check("flt_start_ign", fault, 1);
    check("flt_start_busy", busy, 0);
    fault_clr = 1;
    cyc();
    fault_clr = 0;
    check("flt_clr", fault, 0);
    check("flt_idle", state_dbg, 0);
    period = 8'd2; start = 1;
    cyc();
    start = 0; #1;
    check("rec_busy", busy, 1);
    check("rec_d", ctr_d, 8'hFE);
    cyc(); cyc(); cyc();
    check("rec_expire", expire, 1);
    check("rec_chip", chip_q, 8'h00);

    // reset mid-count
    period = 8'd10; start = 1;
    cyc();
    start = 0;
    cyc(); cyc(); cyc();
    rst = 1;
    cyc();
    check("mrst_clr_n", ctr_clr_n, 0);
    check("mrst_busy", busy, 0);
    check("mrst_d", ctr_d, 0);
    check("mrst_count", ctr_count, 0);
    check("mrst_expire", expire, 0);
    rst = 0;
    cyc();
    check("mrst_clr_n_rel", ctr_clr_n, 1);
    check("mrst_chip", chip_q, 0);

    // start and abort together in idle
    period = 8'd4; start = 1; abort = 1;
    cyc();
    start = 0; abort = 0; #1;
    check("sa_busy", busy, 0);
    check("sa_load", ctr_load, 0);
    check("sa_d", ctr_d, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
